// File: rtl/led_blink_ctrl.sv
// Command-driven LED sequencer: static off/on, continuous blink, or N-blink burst.
// Prescaler ticks pace the phases; commands take effect the cycle after acceptance.
module led_blink_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int HP_W     = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [HP_W-1:0]  cmd_half_period,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int PC_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, BLINK, BURST} state_t;

  state_t           state, state_n;
  logic             led_n, done_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic [HP_W-1:0]  ph, ph_n, hp, hp_n, hp_in;
  logic [CNT_W-1:0] rem, rem_n;
  logic             accept, tick, phase_end;

  assign cmd_ready = (state != BURST);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state != IDLE) && (pc == PC_W'(PRESCALE - 1));
  assign phase_end = tick && (ph == hp - HP_W'(1));
  assign hp_in     = (cmd_half_period == '0) ? HP_W'(1) : cmd_half_period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      led   <= 1'b0;
      done  <= 1'b0;
      pc    <= '0;
      ph    <= '0;
      hp    <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      led   <= led_n;
      done  <= done_n;
      pc    <= pc_n;
      ph    <= ph_n;
      hp    <= hp_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    led_n   = led;
    done_n  = 1'b0;
    pc_n    = pc;
    ph_n    = ph;
    hp_n    = hp;
    rem_n   = rem;

    if (state != IDLE) begin
      pc_n = tick ? '0 : pc + PC_W'(1);
      if (tick) ph_n = phase_end ? '0 : ph + HP_W'(1);
    end

    if (state == BLINK && phase_end) led_n = ~led;

    // A burst cycle is counted off at the end of its low phase.
    if (state == BURST && phase_end) begin
      if (led) begin
        led_n = 1'b0;
      end else if (rem == CNT_W'(1)) begin
        rem_n   = '0;
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        rem_n = rem - CNT_W'(1);
        led_n = 1'b1;
      end
    end

    if (accept) begin
      pc_n = '0;
      ph_n = '0;
      case (cmd_mode)
        2'd0: begin
          state_n = IDLE;
          led_n   = 1'b0;
        end
        2'd1: begin
          state_n = IDLE;
          led_n   = 1'b1;
        end
        2'd2: begin
          state_n = BLINK;
          hp_n    = hp_in;
          led_n   = 1'b1;
        end
        default: begin
          if (cmd_count == '0) begin
            state_n = IDLE;
            led_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = BURST;
            hp_n    = hp_in;
            rem_n   = cmd_count;
            led_n   = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomized bench for led_blink_ctrl; outputs are predicted from elapsed time since each accepted command.
module tb_led_blink_ctrl;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = 2'd0;
  logic [15:0] cmd_half_period = 16'd0;
  logic [7:0]  cmd_count = 8'd0;
  logic        led, busy, done;

  int     checks = 0;
  int     errors = 0;
  int     n_acc = 0;
  longint cyc = 0;

  // Model: 0 = static level, 1 = blinking, 2 = burst; times are edge indices.
  int     m_kind = 0;
  logic   m_led = 1'b0;
  longint m_start = 0;
  longint m_done_cyc = -1;
  int     m_hp = 1;
  int     m_n = 0;

  led_blink_ctrl #(.PRESCALE(P), .HP_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_half_period(cmd_half_period), .cmd_count(cmd_count),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs in the cycle following edge c.
  function automatic void model_outs(input longint c, output logic l, output logic b,
                                     output logic d, output logic r);
    longint e, len;
    e   = c - m_start;
    len = longint'(m_hp) * P;
    l = m_led; b = 1'b0; d = (c == m_done_cyc); r = 1'b1;
    if (m_kind == 1) begin
      l = ((e / len) % 2) == 0; b = 1'b1; d = 1'b0;
    end else if (m_kind == 2) begin
      if (e < 2 * m_n * len) begin
        l = ((e / len) % 2) == 0; b = 1'b1; d = 1'b0; r = 1'b0;
      end else begin
        l = 1'b0; d = (e == 2 * m_n * len);
      end
    end
  endfunction

  always @(posedge rst) begin
    m_kind = 0; m_led = 1'b0; m_done_cyc = -1;
  end

  always @(posedge clk) begin : model_p
    logic l, b, d, r;
    model_outs(cyc, l, b, d, r);
    cyc++;
    if (!rst && cmd_valid && r) begin
      n_acc++;
      m_start    = cyc;
      m_done_cyc = -1;
      m_hp       = (cmd_half_period == 0) ? 1 : int'(cmd_half_period);
      m_n        = int'(cmd_count);
      case (cmd_mode)
        2'd0, 2'd1: begin m_kind = 0; m_led = cmd_mode[0]; end
        2'd2: m_kind = 1;
        default: begin
          if (cmd_count == 0) begin m_kind = 0; m_led = 1'b0; m_done_cyc = cyc; end
          else m_kind = 2;
        end
      endcase
    end
  end

  always @(negedge clk) begin : cmp_p
    logic l, b, d, r;
    model_outs(cyc, l, b, d, r);
    chk("led", led, l);
    chk("busy", busy, b);
    chk("done", done, d);
    chk("cmd_ready", cmd_ready, r);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input int hpv, input int cnt);
    int a0;
    a0 = n_acc;
    cmd_valid = 1'b1; cmd_mode = m;
    cmd_half_period = 16'(hpv); cmd_count = 8'(cnt);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (n_acc != a0) break;
    end
    cmd_valid = 1'b0;
    chk("accept_in_time", logic'(n_acc != a0), 1'b1);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    edges(3);
    rst = 1'b0;
    edges(2);
    chk("rst_led", led, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    // ON then OFF, then async reset with no clock edge
    send(2'd1, 1, 0);
    chk("on_led", led, 1'b1);
    chk("on_busy", busy, 1'b0);
    edges(4);
    send(2'd0, 1, 0);
    chk("off_led", led, 1'b0);
    send(2'd1, 1, 0);
    rst = 1'b1; #1;
    chk("arst_led", led, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ready", cmd_ready, 1'b1);
    edges(1);
    rst = 1'b0;
    edges(3);
    chk("post_rst_led", led, 1'b0);

    // BLINK hp=3: 12-cycle phases
    send(2'd2, 3, 0);
    edges(11);
    chk("blink_hi_last", led, 1'b1);
    edges(1);
    chk("blink_lo_first", led, 1'b0);
    chk("blink_busy", busy, 1'b1);
    edges(12);
    chk("blink_hi_again", led, 1'b1);

    // BURST count=2 hp=2, with a held command waiting behind it
    send(2'd3, 2, 2);
    cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_half_period = 16'd1; cmd_count = 8'd0;
    edges(31);
    chk("burst_last_led", led, 1'b0);
    chk("burst_ready_low", cmd_ready, 1'b0);
    edges(1);
    chk("burst_done", done, 1'b1);
    chk("burst_idle", busy, 1'b0);
    chk("burst_ready_back", cmd_ready, 1'b1);
    edges(1);
    cmd_valid = 1'b0;
    chk("held_cmd_taken", led, 1'b1);
    chk("done_one_cycle", done, 1'b0);

    // Preempt BLINK hp=5, BURST count=0, BLINK hp=0
    send(2'd2, 5, 0);
    edges(5);
    send(2'd0, 1, 0);
    chk("preempt_led", led, 1'b0);
    chk("preempt_busy", busy, 1'b0);
    send(2'd3, 3, 0);
    chk("burst0_done", done, 1'b1);
    chk("burst0_led", led, 1'b0);
    send(2'd2, 0, 0);
    edges(3);
    chk("hp0_hi", led, 1'b1);
    edges(1);
    chk("hp0_lo", led, 1'b0);

    // Reset during second high phase of a 3-cycle burst, then a full rerun
    send(2'd3, 2, 3);
    edges(18);
    rst = 1'b1; #1;
    chk("midburst_led", led, 1'b0);
    chk("midburst_busy", busy, 1'b0);
    edges(1);
    rst = 1'b0;
    edges(2);
    send(2'd3, 2, 3);
    edges(47);
    chk("rerun_pre_done", done, 1'b0);
    chk("rerun_busy", busy, 1'b1);
    edges(1);
    chk("rerun_done", done, 1'b1);

    for (int k = 0; k < 40; k++) begin
      send(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      edges($urandom_range(0, 40));
    end
    send(2'd0, 1, 0);
    edges(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Command-driven sequencer for a single LED output. Accepts mode commands over a valid/ready interface and drives the LED: static off, static on, continuous blink, or a burst of N blinks. It sits between control logic (or a CPU-facing register block) and the board LED pin. An internal prescaler produces timing ticks so that blink rates are human-visible.

Parameters:
PRESCALE, 50000, clk cycles per timing tick (must be >= 2)
HP_W, 16, width of half-period field, in ticks
CNT_W, 8, width of burst count field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
cmd_half_period  input  HP_W  ticks per LED phase (high or low); 0 treated as 1
cmd_count  input  CNT_W  BURST only: number of on/off cycles
led  output  1  registered LED drive, 1=lit
busy  output  1  1 while in BLINK or BURST state
done  output  1  one-cycle pulse on BURST completion

Behaviour:
- Reset (async, any time): state=IDLE, led=0, busy=0, done=0, cmd_ready=1, prescaler and phase/burst counters=0. Reset mid-burst aborts it; no done pulse.
- States: IDLE, BLINK, BURST. busy = (state != IDLE).
- cmd_ready = 1 in IDLE and BLINK, 0 in BURST. Command accepted on the rising edge where cmd_valid & cmd_ready; fields latched that edge.
- Latency: the accepted command takes effect in the next cycle (led, state, busy all registered).
- OFF: state->IDLE, led->0. ON: state->IDLE, led->1.
- BLINK: latch hp = max(cmd_half_period, 1); clear prescaler pc and phase counter ph; led->1; state->BLINK. Runs until a new command is accepted. A new command in BLINK preempts it immediately (same 1-cycle latency). A new BLINK restarts the timing from zero.
- BURST with cmd_count=0: no-op except led->0, done=1 next cycle, state stays IDLE.
- BURST with cmd_count=N>0: latch hp, set remaining=N, clear pc/ph, led->1, state->BURST.
- Timing (BLINK/BURST): pc counts 0..PRESCALE-1 every cycle and wraps; tick = (pc==PRESCALE-1). On tick, if ph==hp-1 then ph->0 and the phase ends, else ph++. Each phase therefore lasts exactly hp*PRESCALE cycles.
- Phase end in BLINK: toggle led.
- Phase end in BURST: a high phase ends -> led->0. A low phase ends -> remaining--. If remaining reaches 0: state->IDLE, led stays 0, done=1 for exactly that one cycle, cmd_ready=1 from that cycle on. Otherwise led->1.
- done is 0 in all other cycles, including BLINK toggles and preemption.
- In IDLE, pc/ph hold at 0. Commands arriving while cmd_ready=0 are not consumed; cmd_valid may stay high until accepted.
- Counter widths: ph is HP_W bits, remaining is CNT_W bits; max values (all ones) must work without overflow.

Test Plan:
(all runs use PRESCALE=4)
- Reset: assert rst mid-cycle with no clock edge -> led=0, busy=0, done=0, cmd_ready=1 immediately; holds after release with no command.
- ON then OFF: accept mode=1 at edge T -> led=1 from T+1; accept mode=0 at T+5 -> led=0 from T+6; busy=0 throughout.
- BLINK hp=3: accept at T -> led=1 for cycles T+1..T+12, 0 for T+13..T+24, 1 from T+25; busy=1, cmd_ready=1, done never asserted.
- BURST count=2, hp=2: accept at T -> led high 8, low 8, high 8, low 8 cycles; done=1 only in cycle T+33 with busy=0 and cmd_ready=1; cmd_valid held high during the burst is not accepted until T+33.
- Preempt and edge cases: BLINK hp=5, then at its 7th cycle accept OFF -> led=0 next cycle, busy=0. BURST count=0 -> single done pulse next cycle, led=0. BLINK hp=0 -> behaves as hp=1 (4-cycle phases).
- Reset mid-burst: BURST count=3, assert rst during the second high phase -> led=0 and busy=0 at once; no done pulse; the next BURST command runs a full 3 cycles.
